elementwise_ctrl: RTL and testbench

Sequencer that drives the elementwise post-processing array over a block of rows. It streams row vectors out of a source buffer, keeps the array enabled with a latched function code, and writes each result row into a destination buffer at the correct pipeline-delayed cycle. It runs one job per start/done handshake and sits between the top-level controller and the elementwise array and buffer ports.

---
 rtl/elementwise_ctrl.sv | 149 ++++++++++++++
 tb/tb_elementwise_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elementwise_ctrl.sv
// elementwise_ctrl: streams source rows through the elementwise array
// and writes each result row back at its pipeline-delayed cycle.
module elementwise_ctrl #(
   parameter int ADDR_W = 8,
   parameter int LAT    = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [3:0]        func_in,
   input  logic [ADDR_W-1:0] src_base,
   input  logic [ADDR_W-1:0] dst_base,
   input  logic [ADDR_W:0]   rows,
   input  logic              stall,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              ew_en,
   output logic [3:0]        ew_func,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_e;

   localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0] CNT_ZERO = '0;

   state_e            state_q, state_d;
   logic [3:0]        func_q, func_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [ADDR_W:0]   rows_q, rows_d;
   logic [ADDR_W:0]   issue_q, issue_d;
   logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
   logic [LAT:0]      vld_q, vld_d;
   logic              last_rd;
   logic              last_wr;

   // Reads issue only while running and not stalled; tail of the
   // in-flight pipe marks the row leaving the array this cycle.
   assign rd_en   = (state_q == RUN) && !stall;
   assign wr_en   = vld_q[LAT];
   assign last_rd = rd_en && ((issue_q + CNT_ONE) == rows_q);
   assign last_wr = wr_en && ((wr_cnt_q + CNT_ONE) == rows_q);

   // Address generation; addresses read as zero when not strobed.
   always_comb begin
      rd_addr = '0;
      wr_addr = '0;
      if (rd_en) begin
         rd_addr = src_q + issue_q[ADDR_W-1:0];
      end
      if (wr_en) begin
         wr_addr = dst_q + wr_cnt_q[ADDR_W-1:0];
      end
   end

   // Status outputs decoded from the state register.
   always_comb begin
      busy    = (state_q == RUN) || (state_q == DRAIN);
      ew_en   = busy;
      done    = (state_q == DONE);
      ew_func = func_q;
   end

   // Next-state, job latching, counters and in-flight pipe.
   always_comb begin
      state_d  = state_q;
      func_d   = func_q;
      src_d    = src_q;
      dst_d    = dst_q;
      rows_d   = rows_q;
      issue_d  = issue_q;
      wr_cnt_d = wr_cnt_q;
      vld_d    = {vld_q[LAT-1:0], rd_en};

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (rows == CNT_ZERO) begin
                  state_d = DONE;
               end else begin
                  func_d   = func_in;
                  src_d    = src_base;
                  dst_d    = dst_base;
                  rows_d   = rows;
                  issue_d  = '0;
                  wr_cnt_d = '0;
                  state_d  = RUN;
               end
            end
         end
         RUN: begin
            if (rd_en) begin
               issue_d = issue_q + CNT_ONE;
            end
            if (last_rd) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (last_wr) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (wr_en) begin
         wr_cnt_d = wr_cnt_q + CNT_ONE;
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         func_q   <= '0;
         src_q    <= '0;
         dst_q    <= '0;
         rows_q   <= '0;
         issue_q  <= '0;
         wr_cnt_q <= '0;
         vld_q    <= '0;
      end else begin
         state_q  <= state_d;
         func_q   <= func_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         rows_q   <= rows_d;
         issue_q  <= issue_d;
         wr_cnt_q <= wr_cnt_d;
         vld_q    <= vld_d;
      end
   end

endmodule

// File: tb/tb_elementwise_ctrl.sv
// tb_elementwise_ctrl: randomized job bench checked cycle by cycle
// against a schedule computed from the sequencing rules.
module tb_elementwise_ctrl;

   localparam int AW   = 8;
   localparam int LAT  = 2;
   localparam int MAXC = 2048;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [3:0]    func_in;
   logic [AW-1:0] src_base;
   logic [AW-1:0] dst_base;
   logic [AW:0]   rows;
   logic          stall;
   logic          busy;
   logic          done;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic          ew_en;
   logic [3:0]    ew_func;
   logic          wr_en;
   logic [AW-1:0] wr_addr;

   int checks   = 0;
   int failures = 0;
   logic [3:0] last_func = 4'd0;

   bit stall_arr [MAXC];
   bit exp_rd    [MAXC];
   int exp_rda   [MAXC];
   bit exp_wr    [MAXC];
   int exp_wra   [MAXC];

   always #5 clk = ~clk;

   elementwise_ctrl #(
      .ADDR_W(AW),
      .LAT   (LAT)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .func_in (func_in),
      .src_base(src_base),
      .dst_base(dst_base),
      .rows    (rows),
      .stall   (stall),
      .busy    (busy),
      .done    (done),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .ew_en   (ew_en),
      .ew_func (ew_func),
      .wr_en   (wr_en),
      .wr_addr (wr_addr)
   );

   // One job from start at cycle 0 until the IDLE cycle after done.
   task automatic run_job(input string nm, input int f, input int s,
                          input int d, input int n, input int pct,
                          input int stall_one, input int restart_at);
      int t;
      int k;
      int last_w;
      int done_c;
      int wcount;
      bit eb;
      logic [3:0] ef;
      for (int c = 0; c < MAXC; c++) begin
         stall_arr[c] = (c < 1500) && ($urandom_range(0, 99) < pct);
         if (c == stall_one) stall_arr[c] = 1'b1;
         exp_rd[c]  = 1'b0;
         exp_wr[c]  = 1'b0;
         exp_rda[c] = 0;
         exp_wra[c] = 0;
      end
      t = 1;
      k = 0;
      last_w = 0;
      while (k < n) begin
         if (!stall_arr[t]) begin
            exp_rd[t]          = 1'b1;
            exp_rda[t]         = (s + k) % (1 << AW);
            exp_wr[t+1+LAT]    = 1'b1;
            exp_wra[t+1+LAT]   = (d + k) % (1 << AW);
            last_w             = t + 1 + LAT;
            k++;
         end
         t++;
      end
      done_c = (n == 0) ? 1 : last_w + 1;
      ef = (n == 0) ? last_func : 4'(f);
      wcount = 0;

      start    = 1'b1;
      func_in  = 4'(f);
      src_base = AW'(s);
      dst_base = AW'(d);
      rows     = (AW+1)'(n);
      stall    = stall_arr[0];
      for (int c = 1; c <= done_c + 1; c++) begin
         @(posedge clk);
         #1;
         stall = stall_arr[c];
         if (c == restart_at) begin
            start    = 1'b1;
            func_in  = 4'd7;
            src_base = AW'($urandom);
            dst_base = AW'($urandom);
            rows     = (AW+1)'($urandom_range(1, 9));
         end else begin
            start = 1'b0;
         end
         #1;
         eb = (n != 0) && (c <= last_w);
         checks++;
         if (rd_en !== exp_rd[c]) begin
            failures++;
            $display("FAIL %s rd_en c=%0d got=%b exp=%b", nm, c, rd_en, exp_rd[c]);
         end
         if (exp_rd[c]) begin
            checks++;
            if (rd_addr !== AW'(exp_rda[c])) begin
               failures++;
               $display("FAIL %s rd_addr c=%0d got=%0d exp=%0d", nm, c, rd_addr, exp_rda[c]);
            end
         end
         checks++;
         if (wr_en !== exp_wr[c]) begin
            failures++;
            $display("FAIL %s wr_en c=%0d got=%b exp=%b", nm, c, wr_en, exp_wr[c]);
         end
         if (wr_en === 1'b1) wcount++;
         if (exp_wr[c]) begin
            checks++;
            if (wr_addr !== AW'(exp_wra[c])) begin
               failures++;
               $display("FAIL %s wr_addr c=%0d got=%0d exp=%0d", nm, c, wr_addr, exp_wra[c]);
            end
         end
         checks++;
         if (busy !== eb || ew_en !== eb) begin
            failures++;
            $display("FAIL %s busy c=%0d got=%b/%b exp=%b", nm, c, busy, ew_en, eb);
         end
         checks++;
         if (done !== (c == done_c)) begin
            failures++;
            $display("FAIL %s done c=%0d got=%b exp=%b", nm, c, done, c == done_c);
         end
         checks++;
         if (ew_func !== ef) begin
            failures++;
            $display("FAIL %s ew_func c=%0d got=%0d exp=%0d", nm, c, ew_func, ef);
         end
      end
      checks++;
      if (wcount != n) begin
         failures++;
         $display("FAIL %s write_count got=%0d exp=%0d", nm, wcount, n);
      end
      last_func = ef;
   endtask

   task automatic test_reset();
      reset    = 1'b0;
      start    = 1'b0;
      stall    = 1'b0;
      func_in  = 4'd0;
      src_base = '0;
      dst_base = '0;
      rows     = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, rd_en, ew_en, wr_en} !== 5'b0 ||
          rd_addr !== '0 || wr_addr !== '0 || ew_func !== 4'd0) begin
         failures++;
         $display("FAIL reset_state got=%b%b%b%b%b ra=%0d wa=%0d f=%0d exp=0",
                  busy, done, rd_en, ew_en, wr_en, rd_addr, wr_addr, ew_func);
      end
      reset = 1'b1;
      #1;
      last_func = 4'd0;
   endtask

   task automatic test_basic();
      run_job("basic", 3, 8, 20, 4, 0, -1, -1);
   endtask

   task automatic test_stall_one();
      run_job("stall_c2", 3, 8, 20, 4, 0, 2, -1);
   endtask

   task automatic test_zero_rows();
      run_job("zero_rows", 9, 5, 6, 0, 30, -1, -1);
   endtask

   task automatic test_wrap();
      run_job("wrap", 5, 254, 255, 3, 0, -1, -1);
   endtask

   task automatic test_restart_ignored();
      run_job("restart_run", 3, 8, 20, 4, 0, -1, 2);
      run_job("restart_drain", 3, 40, 60, 4, 0, -1, 6);
   endtask

   task automatic test_reset_midjob();
      start    = 1'b1;
      func_in  = 4'd3;
      src_base = 8'd8;
      dst_base = 8'd20;
      rows     = 9'd4;
      stall    = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         reset = (c == 3) ? 1'b0 : 1'b1;
         #1;
         if (c == 4) begin
            checks++;
            if ({busy, done, rd_en, ew_en, wr_en} !== 5'b0 ||
                rd_addr !== '0 || wr_addr !== '0 || ew_func !== 4'd0) begin
               failures++;
               $display("FAIL midreset_outputs got=%b%b%b%b%b ra=%0d wa=%0d f=%0d exp=0",
                        busy, done, rd_en, ew_en, wr_en, rd_addr, wr_addr, ew_func);
            end
         end
         if (c > 4) begin
            checks++;
            if (wr_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
               failures++;
               $display("FAIL midreset_quiet c=%0d got wr=%b done=%b busy=%b exp=0",
                        c, wr_en, done, busy);
            end
         end
      end
      last_func = 4'd0;
      run_job("after_reset", 6, 100, 200, 5, 20, -1, -1);
   endtask

   task automatic test_back_to_back();
      run_job("b2b_a", 1, 10, 30, 2, 0, -1, -1);
      run_job("b2b_b", 2, 50, 70, 3, 0, -1, -1);
      run_job("b2b_c", 4, 0, 0, 0, 0, -1, -1);
      run_job("b2b_d", 8, 90, 91, 1, 0, -1, -1);
   endtask

   task automatic test_random();
      for (int j = 0; j < 12; j++) begin
         int n;
         n = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 40);
         run_job("random", $urandom_range(0, 15), $urandom_range(0, 255),
                 $urandom_range(0, 255), n, $urandom_range(0, 50), -1, -1);
      end
   endtask

   task automatic test_full_rows();
      run_job("full_rows", 12, $urandom_range(0, 255),
              $urandom_range(0, 255), 256, 10, -1, -1);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall_one();
      test_zero_rows();
      test_wrap();
      test_restart_ignored();
      test_reset_midjob();
      test_back_to_back();
      test_random();
      test_full_rows();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
